key_move_queue: RTL and testbench

//  Conditions the four raw active-low maze keys (bit0 Up, bit1 Down, bit2 Left, bit3 Right).

---
 rtl/maze_pkg.sv | 17 +
 rtl/key_debounce.sv | 61 ++++++
 rtl/key_move_queue.sv | 93 +++++++++
 tb/tb_key_move_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Types and constants shared by the maze game blocks (key input, VGA renderer, FND score path).
package maze_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DEBOUNCE_MS       = 5;
  localparam int DB_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int KEY_COUNT         = 4;
  localparam int MOVE_DEPTH        = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

endpackage

// File: rtl/key_debounce.sv
// One maze key: 2-FF synchroniser, counter debounce and a one-cycle press pulse on each
// accepted released->held transition.
module key_debounce
  import maze_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_RawN,
  output logic o_Level,
  output logic o_Press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta_n;
  logic          sync_n;
  logic          sync;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Sync flops reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_n <= 1'b1;
      sync_n <= 1'b1;
    end else begin
      meta_n <= i_RawN;
      sync_n <= meta_n;
    end
  end

  assign sync = ~sync_n;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      o_Level <= 1'b0;
      cnt     <= '0;
    end else if (sync == o_Level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      o_Level <= sync;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= o_Level;
    end
  end

  assign o_Press = o_Level & ~level_d;

endmodule

// File: rtl/key_move_queue.sv
// Turns the four raw maze keys into move commands, queued and released one per rising
// edge of the renderer's frame-draw-done level.
module key_move_queue
  import maze_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DEPTH     = MOVE_DEPTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [KEY_COUNT-1:0] i_Key,
  input  logic                 i_fDrawDone,
  output logic                 o_MoveValid,
  output logic [1:0]           o_MoveDir,
  output logic [7:0]           o_PressCnt,
  output logic                 o_Overflow,
  output logic [KEY_COUNT-1:0] o_KeyLevel
);

  localparam int AW = $clog2(DEPTH);

  logic [KEY_COUNT-1:0] press;
  logic                 push;
  dir_e                 push_dir;
  logic [1:0]           mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 draw_prev;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_ok;

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
      .Clk    (Clk),
      .Rst    (Rst),
      .i_RawN (i_Key[k]),
      .o_Level(o_KeyLevel[k]),
      .o_Press(press[k])
    );
  end

  // Scan from the top so the lowest-index key pressed in the same cycle wins.
  always_comb begin
    push     = 1'b0;
    push_dir = DIR_UP;
    for (int k = KEY_COUNT - 1; k >= 0; k--) begin
      if (press[k]) begin
        push     = 1'b1;
        push_dir = dir_e'(k[1:0]);
      end
    end
  end

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop     = i_fDrawDone & ~draw_prev & ~empty;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      draw_prev   <= 1'b0;
      o_MoveValid <= 1'b0;
      o_MoveDir   <= 2'd0;
      o_PressCnt  <= 8'd0;
      o_Overflow  <= 1'b0;
    end else begin
      draw_prev   <= i_fDrawDone;
      o_MoveValid <= pop;
      if (pop) begin
        o_MoveDir <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr     <= wr_ptr + 1'b1;
        o_PressCnt <= o_PressCnt + 8'd1;
      end else if (push) begin
        o_Overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_dir;
    end
  end

endmodule

// File: tb/tb_key_move_queue.sv
// Self-checking bench for key_move_queue: directed scenarios plus randomized key/draw traffic
// checked every cycle against a window-based reference model.
module tb_key_move_queue;
  import maze_pkg::*;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int MAXC  = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key = 4'hF;
  logic       draw = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [7:0] press_cnt;
  logic       overflow;
  logic [3:0] key_level;

  int compared   = 0;
  int mismatched = 0;

  // Model: raw samples per edge (active-high), debounced levels, and the move queue.
  bit [3:0] hist [MAXC];
  int       edge_n   = 0;
  int       rst_edge = 0;
  bit [3:0] m_stable = 4'h0;
  bit [3:0] m_rose   = 4'h0;
  bit       m_prev_draw = 1'b0;
  int       q [$];
  int       m_cnt  = 0;
  bit       m_ovf  = 1'b0;
  bit       m_valid = 1'b0;
  int       m_dir  = 0;
  int       valid_seen = 0;
  int       last_dir   = 0;

  always #5 clk = ~clk;

  key_move_queue #(.DB_CYCLES(DB), .DEPTH(DEPTH)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .i_Key      (key),
    .i_fDrawDone(draw),
    .o_MoveValid(move_valid),
    .o_MoveDir  (move_dir),
    .o_PressCnt (press_cnt),
    .o_Overflow (overflow),
    .o_KeyLevel (key_level)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edge_n);
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare 1 time unit later.
  task automatic tick();
    bit [3:0] key_s;
    bit [3:0] new_rose;
    bit       draw_s;
    bit       rst_s;
    bit       rising;
    bit       do_pop;
    bit       is_full;
    bit       all_diff;
    int       ev;
    key_s  = ~key;
    draw_s = draw;
    rst_s  = rst;
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAXC) begin
      $display("[TB] FAIL cycle_budget: got %0d, expected < %0d", edge_n, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    hist[edge_n] = key_s;
    if (rst_s) begin
      m_stable = '0; m_rose = '0; m_prev_draw = 1'b0;
      q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_valid = 1'b0; m_dir = 0;
      rst_edge = edge_n;
      hist[edge_n] = '0;
      hist[edge_n-1] = '0;
    end else begin
      rising  = draw_s && !m_prev_draw;
      do_pop  = rising && (q.size() > 0);
      is_full = (q.size() == DEPTH);
      ev = -1;
      for (int k = 0; k < 4; k++) if (m_rose[k] && ev < 0) ev = k;
      m_valid = do_pop;
      if (do_pop) m_dir = q.pop_front();
      if (ev >= 0) begin
        if (!is_full || do_pop) begin
          q.push_back(ev);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev_draw = draw_s;
      // A level is accepted once the synchronised key (raw delayed two edges) has
      // disagreed with it on each of the last DB edges since reset.
      for (int k = 0; k < 4; k++) begin
        new_rose[k] = 1'b0;
        if (edge_n - DB >= rst_edge) begin
          all_diff = 1'b1;
          for (int m = edge_n - DB + 1; m <= edge_n; m++)
            if (hist[m-2][k] == m_stable[k]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[k] = ~m_stable[k];
            new_rose[k] = m_stable[k];
          end
        end
      end
      m_rose = new_rose;
    end
    #1;
    checkOutput("key_level", key_level, m_stable);
    checkOutput("move_valid", move_valid, m_valid);
    if (m_valid) checkOutput("move_dir", move_dir, m_dir);
    checkOutput("press_cnt", press_cnt, m_cnt);
    checkOutput("overflow", overflow, m_ovf);
    if (move_valid) begin
      valid_seen++;
      last_dir = move_dir;
    end
  endtask

  task automatic applyStimulus(input bit [3:0] k, input int hold);
    key = k;
    repeat (hold) tick();
  endtask

  task automatic pulse_draw();
    draw = 1'b1;
    repeat (2) tick();
    draw = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #(MAXC * 12);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [3:0] k;
    int       hold;

    // Reset with keys released; a draw pulse on an empty queue yields nothing.
    rst = 1'b1; key = 4'hF; draw = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    valid_seen = 0;
    pulse_draw();
    checkOutput("rst_valid_count", valid_seen, 0);
    checkOutput("rst_key_level", key_level, 0);
    checkOutput("rst_press_cnt", press_cnt, 0);
    checkOutput("rst_overflow", overflow, 0);

    // Down press: level appears exactly 10 edges after the raw change.
    key = 4'b1101;
    repeat (9) tick();
    checkOutput("down_level_edge9", key_level, 0);
    tick();
    checkOutput("down_level_edge10", key_level, 4'b0010);
    repeat (40) tick();
    applyStimulus(4'hF, 20);
    valid_seen = 0;
    pulse_draw();
    checkOutput("down_valid_count", valid_seen, 1);
    checkOutput("down_dir", last_dir, DIR_DOWN);
    checkOutput("down_press_cnt", press_cnt, 1);

    // Bouncing key never settles long enough to be accepted.
    do_reset();
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 4'b1110 : 4'b1111, 3);
    applyStimulus(4'hF, 20);
    checkOutput("bounce_level", key_level, 0);
    checkOutput("bounce_press_cnt", press_cnt, 0);

    // Five Right presses into a four-entry queue.
    do_reset();
    repeat (5) begin
      applyStimulus(4'b0111, 15);
      applyStimulus(4'hF, 15);
    end
    checkOutput("ovf_press_cnt", press_cnt, 4);
    checkOutput("ovf_flag", overflow, 1);
    valid_seen = 0;
    repeat (4) pulse_draw();
    checkOutput("ovf_drain_count", valid_seen, 4);
    checkOutput("ovf_drain_dir", last_dir, DIR_RIGHT);
    pulse_draw();
    checkOutput("ovf_extra_edge", valid_seen, 4);

    // Draw-done held high for 200 cycles releases only one of two queued moves.
    do_reset();
    repeat (2) begin
      applyStimulus(4'b1110, 15);
      applyStimulus(4'hF, 15);
    end
    valid_seen = 0;
    draw = 1'b1;
    repeat (200) tick();
    draw = 1'b0;
    repeat (3) tick();
    checkOutput("held_draw_count", valid_seen, 1);

    // Up and Down pressed together: only Up is queued.
    do_reset();
    applyStimulus(4'b1100, 20);
    applyStimulus(4'hF, 20);
    checkOutput("simul_press_cnt", press_cnt, 1);
    valid_seen = 0;
    repeat (2) pulse_draw();
    checkOutput("simul_valid_count", valid_seen, 1);
    checkOutput("simul_dir", last_dir, DIR_UP);

    // Reset with three queued moves empties the queue.
    do_reset();
    repeat (3) begin
      applyStimulus(4'b1011, 15);
      applyStimulus(4'hF, 15);
    end
    checkOutput("preclear_press_cnt", press_cnt, 3);
    do_reset();
    valid_seen = 0;
    pulse_draw();
    checkOutput("cleared_valid_count", valid_seen, 0);
    checkOutput("cleared_press_cnt", press_cnt, 0);

    // Randomized key patterns, draw toggling and occasional single-cycle resets.
    for (int n = 0; n < 150; n++) begin
      k = 4'($urandom);
      if ($urandom_range(0, 1) == 0) k = 4'hF;
      hold = $urandom_range(1, 25);
      key = k;
      repeat (hold) begin
        if ($urandom_range(0, 5) == 0) draw = ~draw;
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    applyStimulus(4'hF, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
